fb_access_arbiter: RTL
======================

// Module: fb_access_arbiter
// PURPOSE
//  Shares the single-port VGA framebuffer RAM between three requesters: VGA scan-out
//  (reads), the CPU MMIO path (rd/wr) and the graphics engine (rd/wr). Sits between the
//  OTTER MMIO decode / graphics engine and the framebuffer RAM; owns its only port.
//  Fixed priority for VGA; round-robin between CPU and GFX; bounded starvation guard.
// PARAMETERS
//  ADDR_W      13  framebuffer address width (80x60 = 4800 pixels)
//  DATA_W      8   pixel width (RRRGGGBB)
//  STARVE_MAX  4   consecutive VGA-blocked cycles before a waiting CPU/GFX request preempts VGA
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous, active-high reset
//  vga_req     in   1       scan-out read request
//  vga_addr    in   ADDR_W  scan-out read address
//  vga_rdata   out  DATA_W  scan-out read data
//  vga_rvalid  out  1       vga_rdata valid (1 cycle after accepted req)
//  vga_miss    out  1       pulse: VGA request dropped by starvation preemption
//  cpu_req     in   1       CPU access request; held until cpu_gnt
//  cpu_we      in   1       1 = write, 0 = read
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_gnt     out  1       CPU request accepted this cycle
//  cpu_rdata   out  DATA_W  CPU read data
//  cpu_rvalid  out  1       cpu_rdata valid
//  gfx_req/gfx_we/gfx_addr/gfx_wdata/gfx_gnt/gfx_rdata/gfx_rvalid  same as cpu_* for graphics engine
//  fb_we       out  1       RAM write enable
//  fb_addr     out  ADDR_W  RAM address
//  fb_wdata    out  DATA_W  RAM write data
//  fb_rdata    in   DATA_W  RAM read data, valid 1 cycle after fb_addr (synchronous read)
// BEHAVIOUR
//  - Reset: every output 0; rr_ptr = CPU; wait counters 0; pending read tag = NONE.
//  - One access per cycle. Grant is combinational from reqs + registered state; gnt and
//    fb_* driven the same cycle. Unselected cycle: fb_we=0, fb_addr/fb_wdata hold last value.
//  - Winner order: (1) CPU/GFX whose wait_cnt == STARVE_MAX (CPU first if both);
//    (2) vga_req; (3) CPU/GFX by rr_ptr; rr_ptr flips to the other requester after each CPU/GFX grant.
//  - wait_cnt (per CPU/GFX, width clog2(STARVE_MAX+1)): +1 each cycle req=1 and not granted,
//    saturates at STARVE_MAX; cleared on grant or req=0.
//  - Preemption cycle: vga_miss=1 for one cycle, no vga_rvalid for that request.
//  - Read return: registered owner tag; next cycle that owner's rvalid=1 and rdata=fb_rdata.
//    Write grants produce no rvalid. rdata ports hold last value when rvalid=0.
//  - Back-to-back reads by the same requester sustain 1/cycle; no internal buffering.
//  - Write/read same address in consecutive cycles: read sees new data (RAM order); no forwarding.
//  - Requester must hold req/we/addr/wdata stable until gnt; changes before gnt are undefined.
//  - rst mid-operation: pending read tag cleared, no rvalid emitted for in-flight read.
// CONFIGURATION
//  FB_ARB_WAITSTAT_EN defined: adds ports stat_clr (in 1), cpu_wait_total and gfx_wait_total
//    (out 16 each): saturating counts of cycles req=1 && gnt=0; stat_clr synchronous clear,
//    clear wins over same-cycle increment; reset 0.
//  Not defined: ports and counters absent; arbitration identical.
// TESTING
//  1. Reset: rst=1 mid-stream with CPU read in flight -> all outputs 0, no cpu_rvalid after release.
//  2. VGA only: vga_req every cycle, addr 0..9, RAM preloaded addr*3 -> vga_rvalid each
//     next cycle, vga_rdata 0,3,...,27.
//  3. CPU+GFX writes, no VGA: both req continuously -> gnt alternates CPU,GFX,CPU,... starting CPU.
//  4. CPU write addr 0x100=0xA5 then GFX read 0x100 -> gfx_rdata=0xA5, gfx_rvalid 1 cycle after gfx_gnt.
//  5. Starvation: vga_req=1 constantly, cpu_req=1 read at cycle 0 -> cpu_gnt at cycle 4,
//     vga_miss=1 that cycle, cpu_rvalid at cycle 5, VGA resumes cycle 5.
//  6. FB_ARB_WAITSTAT_EN: scenario 5 -> cpu_wait_total=4; stat_clr=1 -> 0 next cycle.

Source files
------------

// File: rtl/fb_access_arbiter_if.sv
// fb_access_arbiter_if: request/response bundle between the framebuffer arbiter,
// its three requesters (VGA scan-out, CPU MMIO, graphics engine) and the RAM port.
//   slave  : arbiter view (requests and fb_rdata in; grants, read returns, fb_* out)
//   master : requester/RAM view (the mirror image)
interface fb_access_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic              vga_miss;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              gfx_req;
    logic              gfx_we;
    logic [ADDR_W-1:0] gfx_addr;
    logic [DATA_W-1:0] gfx_wdata;
    logic              gfx_gnt;
    logic [DATA_W-1:0] gfx_rdata;
    logic              gfx_rvalid;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_wdata;
    logic [DATA_W-1:0] fb_rdata;
    modport slave (
        input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               gfx_req, gfx_we, gfx_addr, gfx_wdata, fb_rdata,
        output vga_rdata, vga_rvalid, vga_miss, cpu_gnt, cpu_rdata, cpu_rvalid,
               gfx_gnt, gfx_rdata, gfx_rvalid, fb_we, fb_addr, fb_wdata
    );
    modport master (
        output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
               gfx_req, gfx_we, gfx_addr, gfx_wdata, fb_rdata,
        input  vga_rdata, vga_rvalid, vga_miss, cpu_gnt, cpu_rdata, cpu_rvalid,
               gfx_gnt, gfx_rdata, gfx_rvalid, fb_we, fb_addr, fb_wdata
    );
endinterface

// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: single-port framebuffer RAM arbiter for VGA scan-out, CPU and GFX.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fb_access_arbiter_if.slave (requests, grants, read returns, RAM port)
//   FB_ARB_WAITSTAT_EN adds stat_clr_i, cpu_wait_total_o, gfx_wait_total_o
//   (16-bit saturating counts of cycles spent requesting without a grant).
// VGA has priority, CPU/GFX share round-robin, and a CPU/GFX request that has waited
// STARVE_MAX cycles preempts VGA (the VGA request is dropped and flagged on vga_miss).
module fb_access_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef FB_ARB_WAITSTAT_EN
    input  logic                stat_clr_i,
    output logic [15:0]         cpu_wait_total_o,
    output logic [15:0]         gfx_wait_total_o,
`endif
    fb_access_arbiter_if.slave  bus
);
    localparam int WW = $clog2(STARVE_MAX + 1);
    localparam logic [WW-1:0] WMAX = WW'(STARVE_MAX);
    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_VGA  = 2'd1;
    localparam logic [1:0] TAG_CPU  = 2'd2;
    localparam logic [1:0] TAG_GFX  = 2'd3;
    localparam logic RR_CPU = 1'b0;
    localparam logic RR_GFX = 1'b1;
    logic              cpu_starve, gfx_starve, cpu_win, gfx_win, vga_win;
    logic [WW-1:0]     cpu_wait_q, cpu_wait_d, gfx_wait_q, gfx_wait_d;
    logic              rr_q, rr_d;
    logic [1:0]        tag_q, tag_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d, cpu_rdata_q, cpu_rdata_d, gfx_rdata_q, gfx_rdata_d;
    always_comb begin
        cpu_starve      = bus.cpu_req && cpu_wait_q == WMAX;
        gfx_starve      = bus.gfx_req && gfx_wait_q == WMAX;
        // Grants are masked while rst is high so every output reads 0 during reset.
        cpu_win         = !rst && (cpu_starve || (!gfx_starve && !bus.vga_req && bus.cpu_req &&
                                                  (rr_q == RR_CPU || !bus.gfx_req)));
        gfx_win         = !rst && !cpu_starve && (gfx_starve || (!bus.vga_req && bus.gfx_req &&
                                                                 (rr_q == RR_GFX || !bus.cpu_req)));
        vga_win         = !rst && bus.vga_req && !cpu_starve && !gfx_starve;
        bus.vga_miss    = !rst && bus.vga_req && (cpu_starve || gfx_starve);
        bus.cpu_gnt     = cpu_win;
        bus.gfx_gnt     = gfx_win;
        addr_d          = cpu_win ? bus.cpu_addr : gfx_win ? bus.gfx_addr : vga_win ? bus.vga_addr : addr_q;
        wdata_d         = cpu_win ? bus.cpu_wdata : gfx_win ? bus.gfx_wdata : wdata_q;
        bus.fb_we       = (cpu_win && bus.cpu_we) || (gfx_win && bus.gfx_we);
        bus.fb_addr     = addr_d;
        bus.fb_wdata    = wdata_d;
        cpu_wait_d      = (!bus.cpu_req || cpu_win) ? '0 : cpu_wait_q == WMAX ? WMAX : cpu_wait_q + 1'b1;
        gfx_wait_d      = (!bus.gfx_req || gfx_win) ? '0 : gfx_wait_q == WMAX ? WMAX : gfx_wait_q + 1'b1;
        rr_d            = cpu_win ? RR_GFX : gfx_win ? RR_CPU : rr_q;
        // Remember who owns the read now on the RAM; its data appears next cycle.
        tag_d           = vga_win ? TAG_VGA : (cpu_win && !bus.cpu_we) ? TAG_CPU :
                          (gfx_win && !bus.gfx_we) ? TAG_GFX : TAG_NONE;
        bus.vga_rvalid  = tag_q == TAG_VGA;
        bus.cpu_rvalid  = tag_q == TAG_CPU;
        bus.gfx_rvalid  = tag_q == TAG_GFX;
        vga_rdata_d     = bus.vga_rvalid ? bus.fb_rdata : vga_rdata_q;
        cpu_rdata_d     = bus.cpu_rvalid ? bus.fb_rdata : cpu_rdata_q;
        gfx_rdata_d     = bus.gfx_rvalid ? bus.fb_rdata : gfx_rdata_q;
        bus.vga_rdata   = vga_rdata_d;
        bus.cpu_rdata   = cpu_rdata_d;
        bus.gfx_rdata   = gfx_rdata_d;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_wait_q  <= '0;
            gfx_wait_q  <= '0;
            rr_q        <= RR_CPU;
            tag_q       <= TAG_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            vga_rdata_q <= '0;
            cpu_rdata_q <= '0;
            gfx_rdata_q <= '0;
        end else begin
            cpu_wait_q  <= cpu_wait_d;
            gfx_wait_q  <= gfx_wait_d;
            rr_q        <= rr_d;
            tag_q       <= tag_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            vga_rdata_q <= vga_rdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            gfx_rdata_q <= gfx_rdata_d;
        end
    end
`ifdef FB_ARB_WAITSTAT_EN
    logic [15:0] cpu_tot_q, cpu_tot_d, gfx_tot_q, gfx_tot_d;
    always_comb begin
        cpu_tot_d = stat_clr_i ? '0 : (bus.cpu_req && !cpu_win && cpu_tot_q != 16'hFFFF) ? cpu_tot_q + 1'b1 : cpu_tot_q;
        gfx_tot_d = stat_clr_i ? '0 : (bus.gfx_req && !gfx_win && gfx_tot_q != 16'hFFFF) ? gfx_tot_q + 1'b1 : gfx_tot_q;
        cpu_wait_total_o = cpu_tot_q;
        gfx_wait_total_o = gfx_tot_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_tot_q <= '0;
            gfx_tot_q <= '0;
        end else begin
            cpu_tot_q <= cpu_tot_d;
            gfx_tot_q <= gfx_tot_d;
        end
    end
`endif
endmodule
